// File: rtl/ls_mem_issue.sv
// ls_mem_issue
//   Issue stage behind the load/store queue. Takes the head cell's lw/sw,
//   waits for operands, computes the effective address, runs one data-memory
//   access over a req/ready handshake, writes back load data and pulses
//   can_move so the queue advances. Non-lw/sw instructions are dropped with
//   an illegal pulse.
//
//   Optional build macro: LS_STORE_FORWARD_EN
//     Keeps a single last-store entry. A load whose address matches the entry
//     completes from it without touching memory. The entry is cleared by reset.
//
// Ports
//   clock, reset_sync        : clock, synchronous active-high reset
//   head_instr               : LS queue head cell (0 = empty)
//   rs_val/rs_ready          : base register operand
//   rd_val/rd_ready          : store data operand (sw only)
//   can_move                 : one-cycle pulse, head retired
//   mem_req/we/addr/wdata    : memory request, held until mem_ready
//   mem_ready                : memory accepts the request this cycle
//   mem_rvalid/mem_rdata     : load response
//   wb_valid/wb_tag/wb_data  : one-cycle load writeback
//   illegal                  : one-cycle pulse, unknown opcode discarded
//
// All pulse outputs are registered, so they appear one cycle after the FSM
// decides on them (can_move follows the DONE state by one cycle).
module ls_mem_issue #(
    parameter int ADDR_WIDTH = 12,
    parameter int REG_BITS   = 5
) (
    input  logic                  clock,
    input  logic                  reset_sync,
    input  logic [31:0]           head_instr,
    input  logic [31:0]           rs_val,
    input  logic                  rs_ready,
    input  logic [31:0]           rd_val,
    input  logic                  rd_ready,
    output logic                  can_move,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata,
    output logic                  wb_valid,
    output logic [REG_BITS-1:0]   wb_tag,
    output logic [31:0]           wb_data,
    output logic                  illegal
);

    typedef enum logic [2:0] {IDLE, ADDR, REQ, WAIT, DONE} state_t;

    localparam logic [4:0] OP_SW = 5'b00111;
    localparam logic [4:0] OP_LW = 5'b01000;

    state_t                state_q, state_d;
    logic [31:0]           instr_q, instr_d;
    logic [31:0]           ea_q, ea_d;
    logic [31:0]           sdata_q, sdata_d;
    logic [31:0]           ldata_q, ldata_d;
    logic                  can_move_q, can_move_d;
    logic                  illegal_q, illegal_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [REG_BITS-1:0]   wb_tag_q, wb_tag_d;
    logic [31:0]           wb_data_q, wb_data_d;
    logic                  mem_req_q, mem_req_d;

    logic [4:0]            head_op;
    logic                  cur_sw;
    logic [4:0]            cur_rd;
    logic [31:0]           ea_calc;
    logic                  operands_ok;
    logic                  fwd_hit;
    logic                  unused_bits;

    assign head_op     = head_instr[31:27];
    assign cur_sw      = (instr_q[31:27] == OP_SW);
    assign cur_rd      = instr_q[26:22];
    assign ea_calc     = rs_val + {{15{instr_q[16]}}, instr_q[16:0]};
    assign operands_ok = rs_ready & (~cur_sw | rd_ready);
    assign unused_bits = ^{ea_q[31:ADDR_WIDTH], instr_q[21:17]};

`ifdef LS_STORE_FORWARD_EN
    logic                  fwd_vld_q, fwd_vld_d;
    logic [ADDR_WIDTH-1:0] fwd_addr_q, fwd_addr_d;
    logic [31:0]           fwd_data_q, fwd_data_d;

    assign fwd_hit = ~cur_sw & fwd_vld_q & (fwd_addr_q == ea_calc[ADDR_WIDTH-1:0]);
`else
    assign fwd_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        ea_d       = ea_q;
        sdata_d    = sdata_q;
        ldata_d    = ldata_q;
        can_move_d = 1'b0;
        illegal_d  = 1'b0;
        wb_valid_d = 1'b0;
        wb_tag_d   = '0;
        wb_data_d  = '0;
`ifdef LS_STORE_FORWARD_EN
        fwd_vld_d  = fwd_vld_q;
        fwd_addr_d = fwd_addr_q;
        fwd_data_d = fwd_data_q;
`endif
        case (state_q)
            IDLE: begin
                // While can_move is high the queue has not shifted yet, so
                // the head still holds the instruction just retired.
                if (head_instr != '0 && !can_move_q) begin
                    if (head_op == OP_LW || head_op == OP_SW) begin
                        instr_d = head_instr;
                        state_d = ADDR;
                    end else begin
                        can_move_d = 1'b1;
                        illegal_d  = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (operands_ok) begin
                    ea_d = ea_calc;
                    if (cur_sw) sdata_d = rd_val;
                    if (fwd_hit) begin
`ifdef LS_STORE_FORWARD_EN
                        ldata_d = fwd_data_q;
`endif
                        state_d = DONE;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_req_q && mem_ready) begin
                    state_d = cur_sw ? DONE : WAIT;
`ifdef LS_STORE_FORWARD_EN
                    if (cur_sw) begin
                        fwd_vld_d  = 1'b1;
                        fwd_addr_d = ea_q[ADDR_WIDTH-1:0];
                        fwd_data_d = sdata_q;
                    end
`endif
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    ldata_d = mem_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                can_move_d = 1'b1;
                if (!cur_sw && cur_rd != 5'd0) begin
                    wb_valid_d = 1'b1;
                    wb_tag_d   = REG_BITS'(cur_rd);
                    wb_data_d  = ldata_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Request is a registered decode of the next state, so it rises
        // together with REQ and drops on the cycle after acceptance.
        mem_req_d = (state_d == REQ);
    end

    always_ff @(posedge clock) begin
        if (reset_sync) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            ea_q       <= '0;
            sdata_q    <= '0;
            ldata_q    <= '0;
            can_move_q <= 1'b0;
            illegal_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_tag_q   <= '0;
            wb_data_q  <= '0;
            mem_req_q  <= 1'b0;
`ifdef LS_STORE_FORWARD_EN
            fwd_vld_q  <= 1'b0;
            fwd_addr_q <= '0;
            fwd_data_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            ea_q       <= ea_d;
            sdata_q    <= sdata_d;
            ldata_q    <= ldata_d;
            can_move_q <= can_move_d;
            illegal_q  <= illegal_d;
            wb_valid_q <= wb_valid_d;
            wb_tag_q   <= wb_tag_d;
            wb_data_q  <= wb_data_d;
            mem_req_q  <= mem_req_d;
`ifdef LS_STORE_FORWARD_EN
            fwd_vld_q  <= fwd_vld_d;
            fwd_addr_q <= fwd_addr_d;
            fwd_data_q <= fwd_data_d;
`endif
        end
    end

    assign can_move  = can_move_q;
    assign illegal   = illegal_q;
    assign wb_valid  = wb_valid_q;
    assign wb_tag    = wb_tag_q;
    assign wb_data   = wb_data_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_req_q & cur_sw;
    assign mem_addr  = ea_q[ADDR_WIDTH-1:0];
    assign mem_wdata = sdata_q;

endmodule
